// File: rtl/readout_pkg.sv
// Shared types and helpers for the readout sequencer and its arbiter.
package readout_pkg;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

  // Default line length in bits; must match the shift register it drives.
  localparam int DEFAULT_WIDTH = 512;

  // Width of a channel index; a single channel still gets a 1-bit id.
  function automatic int ch_id_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/readout_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester searching
// upward from last_grant+1 and wrapping at NUM_CH.
module rr_arbiter
  import readout_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]          req,
  input  logic [ch_id_w(NUM_CH)-1:0] last_grant,
  output logic                       grant_valid,
  output logic [ch_id_w(NUM_CH)-1:0] grant_idx
);

  localparam int ID_W = ch_id_w(NUM_CH);

  int cand;

  // Rotating priority search; the first hit in scan order wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = {ID_W{1'b0}};
    cand        = 0;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = (int'(last_grant) + i) % NUM_CH;
      for (int j = 0; j < NUM_CH; j++) begin
        if (!grant_valid && (cand == j) && req[j]) begin
          grant_valid = 1'b1;
          grant_idx   = ID_W'(j);
        end else begin
          grant_valid = grant_valid;
        end
      end
    end
  end

endmodule

// File: rtl/readout_sequencer.sv
// Readout sequencer: time-shares one serial-to-parallel shift register
// between NUM_CH serial line sources. Grants one channel at a time,
// streams WIDTH bits into the register, pulses load, then reports the
// captured line with its channel id.
module readout_sequencer
  import readout_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic [NUM_CH-1:0]          ch_req,
  input  logic [NUM_CH-1:0]          ch_data,
  output logic [NUM_CH-1:0]          ch_grant,
  output logic                       sr_shift_in,
  output logic                       sr_load,
  output logic                       busy,
  output logic                       out_valid,
  output logic [ch_id_w(NUM_CH)-1:0] out_ch,
  output logic [CNT_W-1:0]           line_count
);

  localparam int ID_W  = ch_id_w(NUM_CH);
  localparam int BIT_W = $clog2(WIDTH);

  // Bit counter value of the final SHIFT cycle of a line.
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);
  // Reset value of the pointer so that channel 0 wins the first scan.
  localparam logic [ID_W-1:0]  PTR_INIT = ID_W'(NUM_CH - 1);

  state_t           state_r;
  logic [ID_W-1:0]  sel_r;
  logic [ID_W-1:0]  last_grant_r;
  logic [BIT_W-1:0] bit_cnt_r;

  logic             grant_valid_s;
  logic [ID_W-1:0]  grant_idx_s;
  logic             sel_bit_s;

  // One-hot decode of a channel index.
  function automatic logic [NUM_CH-1:0] to_one_hot(input logic [ID_W-1:0] idx);
    logic [NUM_CH-1:0] oh;
    for (int j = 0; j < NUM_CH; j++) begin
      oh[j] = (idx == ID_W'(j));
    end
    return oh;
  endfunction

  rr_arbiter #(
    .NUM_CH(NUM_CH)
  ) u_arb (
    .req        (ch_req),
    .last_grant (last_grant_r),
    .grant_valid(grant_valid_s),
    .grant_idx  (grant_idx_s)
  );

  // Route the selected channel's serial bit to the register, only in SHIFT;
  // this path must stay combinational so bit k lands in SHIFT cycle k.
  always_comb begin
    sel_bit_s = 1'b0;
    for (int j = 0; j < NUM_CH; j++) begin
      sel_bit_s = sel_bit_s | (ch_data[j] & (sel_r == ID_W'(j)));
    end
    sr_shift_in = (state_r == SHIFT) ? sel_bit_s : 1'b0;
  end

  // Sequencer FSM with bit counter and registered strobes/status.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      sel_r        <= {ID_W{1'b0}};
      last_grant_r <= PTR_INIT;
      bit_cnt_r    <= {BIT_W{1'b0}};
      ch_grant     <= {NUM_CH{1'b0}};
      sr_load      <= 1'b0;
      busy         <= 1'b0;
      out_valid    <= 1'b0;
      out_ch       <= {ID_W{1'b0}};
      line_count   <= {CNT_W{1'b0}};
    end else begin
      out_valid <= 1'b0;
      sr_load   <= 1'b0;
      case (state_r)
        IDLE: begin
          // The out_valid cycle is an IDLE cycle and may start the next line.
          if (enable && grant_valid_s) begin
            state_r      <= SHIFT;
            sel_r        <= grant_idx_s;
            last_grant_r <= grant_idx_s;
            bit_cnt_r    <= {BIT_W{1'b0}};
            ch_grant     <= to_one_hot(grant_idx_s);
            busy         <= 1'b1;
          end else begin
            ch_grant <= {NUM_CH{1'b0}};
            busy     <= 1'b0;
          end
        end
        SHIFT: begin
          // Requests and enable are ignored until the line is complete.
          if (bit_cnt_r == LAST_BIT) begin
            state_r   <= LOAD;
            sr_load   <= 1'b1;
            ch_grant  <= {NUM_CH{1'b0}};
            bit_cnt_r <= {BIT_W{1'b0}};
          end else begin
            bit_cnt_r <= bit_cnt_r + BIT_W'(1'b1);
          end
        end
        LOAD: begin
          state_r    <= IDLE;
          busy       <= 1'b0;
          out_valid  <= 1'b1;
          out_ch     <= sel_r;
          line_count <= line_count + CNT_W'(1'b1);
        end
        default: begin
          state_r   <= IDLE;
          ch_grant  <= {NUM_CH{1'b0}};
          busy      <= 1'b0;
          bit_cnt_r <= {BIT_W{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_readout_sequencer.sv
// Self-checking bench for readout_sequencer (WIDTH=8, NUM_CH=4, CNT_W=2).
// A bench-side shift register consumes sr_shift_in/sr_load; a line-level
// model predicts every output each cycle.
module tb_readout_sequencer;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset_n, enable;
  logic [N-1:0]  ch_req, ch_data, ch_grant;
  logic          sr_shift_in, sr_load, busy, out_valid;
  logic [1:0]    out_ch;
  logic [CW-1:0] line_count;

  always #5 clk = ~clk;

  readout_sequencer #(.WIDTH(W), .NUM_CH(N), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .ch_req(ch_req),
    .ch_data(ch_data), .ch_grant(ch_grant), .sr_shift_in(sr_shift_in),
    .sr_load(sr_load), .busy(busy), .out_valid(out_valid), .out_ch(out_ch),
    .line_count(line_count)
  );

  // Environment shift register (shift left, MSB first) and its output word.
  logic [W-1:0] sreg, dout;

  // Line-level model: pos = cycles since the grant (0 when no line active);
  // SHIFT occupies pos 1..W, LOAD is pos W+1.
  int           pos, owner, last, cnt, m_och;
  bit           m_valid, known;
  logic [W-1:0] cur_word, valid_word;
  bit           force_en;
  logic [W-1:0] force_word;

  int checks = 0, failures = 0, cyc = 0, grant_cycles = 0;
  int ev_ch[$], ev_cnt[$], ev_cyc[$];
  logic [W-1:0] ev_data[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_events();
    ev_ch.delete(); ev_cnt.delete(); ev_cyc.delete(); ev_data.delete();
  endtask

  // One clock cycle: drive inputs, compare outputs to the model, advance both.
  task automatic cycle(input logic rst, input logic en, input logic [N-1:0] req);
    logic         s_shift, s_load, found;
    logic [N-1:0] exp_grant;
    int           c, winner;
    @(negedge clk);
    reset_n = rst; enable = en; ch_req = req;
    ch_data = N'($urandom);
    if (known && pos >= 1 && pos <= W) ch_data[owner] = cur_word[W-pos];
    #1;
    cyc++;
    if (known) begin
      exp_grant = (pos >= 1 && pos <= W) ? N'(1 << owner) : '0;
      chk("ch_grant", ch_grant, exp_grant);
      chk("sr_shift_in", sr_shift_in, (pos >= 1 && pos <= W) ? cur_word[W-pos] : 1'b0);
      chk("sr_load", sr_load, (pos == W + 1) ? 1'b1 : 1'b0);
      chk("busy", busy, (pos >= 1 && pos <= W + 1) ? 1'b1 : 1'b0);
      chk("out_valid", out_valid, m_valid);
      chk("out_ch", out_ch, m_och);
      chk("line_count", line_count, cnt);
      if (m_valid) chk("data_out", dout, valid_word);
    end
    if (out_valid === 1'b1) begin
      ev_ch.push_back(out_ch); ev_cnt.push_back(line_count);
      ev_cyc.push_back(cyc);   ev_data.push_back(dout);
    end
    if (ch_grant !== '0) grant_cycles++;
    s_shift = sr_shift_in; s_load = sr_load;
    @(posedge clk);
    if (!rst) begin
      sreg = '0; dout = '0;
    end else if (s_load) begin
      dout = sreg; sreg = '0;
    end else begin
      sreg = {sreg[W-2:0], s_shift};
    end
    if (!rst) begin
      pos = 0; last = N - 1; cnt = 0; m_och = 0; m_valid = 0; known = 1;
    end else begin
      m_valid = 0;
      if (pos == 0) begin
        if (en && req != '0) begin
          found = 0; winner = 0;
          for (int i = 1; i <= N; i++) begin
            c = (last + i) % N;
            if (!found && req[c]) begin found = 1; winner = c; end
          end
          owner = winner; last = winner; pos = 1;
          cur_word = force_en ? force_word : W'($urandom);
        end
      end else if (pos <= W) begin
        pos++;
      end else begin
        pos = 0; m_valid = 1; m_och = owner;
        cnt = (cnt + 1) % (1 << CW); valid_word = cur_word;
      end
    end
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, '0);
  endtask

  initial begin
    int gc0;
    int exp_q[$];
    reset_n = 1'b0; enable = 1'b0; ch_req = '0; ch_data = '0;
    sreg = '0; dout = '0; known = 0; pos = 0; last = N - 1; cnt = 0;
    m_och = 0; m_valid = 0; owner = 0; cur_word = '0; valid_word = '0;
    force_en = 0; force_word = '0;

    // Reset values.
    do_reset();
    #2;
    chk("rst_grant", ch_grant, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_load", sr_load, 1'b0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_out_ch", out_ch, 2'd0);
    chk("rst_count", line_count, 2'd0);

    // Single line from ch0 carrying 1,0,1,1,0,0,1,0.
    clear_events(); force_en = 1; force_word = 8'hB2; gc0 = grant_cycles;
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 4'b0001);
    cycle(1'b1, 1'b1, 4'b0000);
    force_en = 0;
    chk("single_events", ev_ch.size(), 1);
    if (ev_ch.size() == 1) begin
      chk("single_data", ev_data[0], 8'hB2);
      chk("single_ch", ev_ch[0], 0);
      chk("single_count", ev_cnt[0], 1);
    end
    chk("single_grant_cycles", grant_cycles - gc0, 8);

    // Round robin over all four requesters, 10 cycles per line.
    do_reset(); clear_events();
    for (int i = 0; i < 41; i++) cycle(1'b1, 1'b1, 4'b1111);
    chk("rr_events", ev_ch.size(), 4);
    if (ev_ch.size() == 4) begin
      for (int k = 0; k < 4; k++) chk("rr_ch", ev_ch[k], k);
      for (int k = 1; k < 4; k++) chk("rr_spacing", ev_cyc[k] - ev_cyc[k-1], 10);
    end

    // Skip non-requesters; ch0 raised mid-line during the third line.
    do_reset(); clear_events();
    for (int i = 0; i < 25; i++) cycle(1'b1, 1'b1, 4'b1010);
    for (int i = 0; i < 30; i++) cycle(1'b1, 1'b1, 4'b1011);
    exp_q = '{1, 3, 1, 3, 0};
    chk("skip_events", ev_ch.size(), 5);
    if (ev_ch.size() == 5) begin
      for (int k = 0; k < 5; k++) chk("skip_ch", ev_ch[k], exp_q[k]);
    end

    // enable dropped in SHIFT cycle 3: line completes, no new grant.
    do_reset(); clear_events(); gc0 = grant_cycles;
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 4'b0001);
    for (int i = 0; i < 21; i++) cycle(1'b1, 1'b0, 4'b0001);
    chk("en_events", ev_ch.size(), 1);
    chk("en_grant_cycles", grant_cycles - gc0, 8);
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1, 4'b0001);
    chk("en_resume_events", ev_ch.size(), 2);

    // Reset in SHIFT cycle 4 of the second line abandons it.
    do_reset(); clear_events();
    for (int i = 0; i < 15; i++) cycle(1'b1, 1'b1, 4'b1111);
    cycle(1'b0, 1'b1, 4'b1111);
    #2;
    chk("midrst_grant", ch_grant, 4'b0000);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_load", sr_load, 1'b0);
    chk("midrst_count", line_count, 2'd0);
    chk("midrst_before_events", ev_ch.size(), 1);
    clear_events();
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1, 4'b1111);
    chk("midrst_events", ev_ch.size(), 1);
    if (ev_ch.size() == 1) begin
      chk("midrst_first_ch", ev_ch[0], 0);
      chk("midrst_first_count", ev_cnt[0], 1);
    end

    // line_count wraps modulo 4; single requester granted every line.
    do_reset(); clear_events();
    for (int i = 0; i < 51; i++) cycle(1'b1, 1'b1, 4'b0001);
    exp_q = '{1, 2, 3, 0, 1};
    chk("wrap_events", ev_cnt.size(), 5);
    if (ev_cnt.size() == 5) begin
      for (int k = 0; k < 5; k++) begin
        chk("wrap_count", ev_cnt[k], exp_q[k]);
        chk("wrap_ch", ev_ch[k], 0);
      end
    end

    // Randomized traffic, occasional reset and enable drops.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 199) != 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0,
            N'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/readout_sequencer.md
Name: readout_sequencer

Overview:
- Sequences the serial-to-parallel readout shift register and time-shares it between NUM_CH serial pixel-line sources.
- Arbitrates round-robin among requesting channels and streams exactly WIDTH bits from the winner into the register.
- Pulses the register's load input to capture the line, then flags the parallel word as valid together with its channel id.
- Sits between the per-channel serializers and the downstream parallel-word consumer.

Parameters:
- WIDTH, 512, line length in bits; must match the shift register WIDTH; at least 2.
- NUM_CH, 4, number of requesting serial channels; at least 1.
- CNT_W, 16, width of the completed-line counter.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset, sampled on the rising clk edge.
- enable  in  1  allows new grants; never aborts a line already in progress.
- ch_req  in  NUM_CH  per-channel line-ready request; level-sensitive.
- ch_data  in  NUM_CH  per-channel serial bit, MSB of the line first.
- ch_grant  out  NUM_CH  one-hot; high only during the SHIFT state of the granted channel.
- sr_shift_in  out  1  drives the shift register's shift_in input.
- sr_load  out  1  drives the shift register's load input.
- busy  out  1  high in SHIFT and LOAD.
- out_valid  out  1  one-cycle pulse; the shift register's data_out holds the new line in this cycle.
- out_ch  out  $clog2(NUM_CH), min 1  channel id of the last captured line; held until the next out_valid.
- line_count  out  CNT_W  number of completed lines; wraps modulo 2^CNT_W.

Behaviour:
- Reset values: state IDLE; ch_grant 0; sr_load 0; sr_shift_in 0; busy 0; out_valid 0; out_ch 0; line_count 0; bit counter 0; last-grant pointer NUM_CH-1, so ch0 wins first.
- A reset applied mid-line abandons the line: no out_valid and no count increment. The shift register is reset by the same reset_n.
- FSM states: IDLE, SHIFT, LOAD.
- IDLE -> SHIFT when enable=1 and ch_req is nonzero.
  - Winner is the first requester searching upward from last_grant+1, wrapping at NUM_CH.
  - The winner index is registered into sel, and last_grant is updated to sel.
  - The bit counter is cleared, and ch_grant is set to the one-hot form of sel.
- In SHIFT:
  - sr_shift_in equals ch_data[sel], combinational from the registered sel.
  - The bit counter increments each cycle; the channel must present line bit k in SHIFT cycle k, for k = 0..WIDTH-1.
  - At count WIDTH-1 the FSM moves to LOAD.
  - ch_req and enable changes are ignored until the line completes.
- In LOAD (1 cycle):
  - sr_load=1, sr_shift_in=0, ch_grant=0. The shift register copies its contents to data_out and clears.
  - The FSM moves to IDLE, with out_valid=1, out_ch=sel, and line_count+1 registered for that IDLE cycle.
- The IDLE cycle carrying out_valid may itself arbitrate, so back-to-back lines take WIDTH+2 cycles each.
- Bit ordering: the bit from SHIFT cycle 0 lands in data_out[WIDTH-1]; the bit from SHIFT cycle WIDTH-1 lands in data_out[0].
- sr_shift_in is 0 in every cycle outside SHIFT.
- No request, or enable=0, in IDLE: stay in IDLE; all strobes stay 0.
- enable deasserted during SHIFT: the line completes normally; the FSM then holds in IDLE.
- A single requester holding its request is granted on every line.
- NUM_CH=1: arbitration degenerates to ch0.
- The bit counter width is $clog2(WIDTH); it never exceeds WIDTH-1.

Decomposition:
- Package readout_pkg holds:
  - state encoding constants IDLE/SHIFT/LOAD;
  - a default WIDTH of 512;
  - a helper function for the channel-id width.
- Sub-module rr_arbiter (parameter NUM_CH): inputs req and last_grant; outputs grant_valid and grant_idx; purely combinational.
- The FSM, bit counter and output registers live in readout_sequencer.

Test Plan:
- Simulate with WIDTH=8, NUM_CH=4, the sequencer connected to a shift_register instance.
- Single line: ch_req=4'b0001, enable=1, ch0 streams 1,0,1,1,0,0,1,0 -> ch_grant=0001 for 8 cycles, then sr_load for 1 cycle. Next cycle: out_valid=1, data_out=8'hB2, out_ch=0, line_count=1.
- Round-robin: ch_req=4'b1111 held for 4 lines -> out_ch sequence 0,1,2,3. Lines are 10 cycles apart; out_valid pulses are 10 cycles apart.
- Skip non-requesters: ch_req=4'b1010 -> grants go ch1, ch3, ch1. A request raised on ch0 mid-line is first served after the next scan reaches it.
- enable dropped in SHIFT cycle 3 -> the line completes with out_valid=1. No further grant until enable=1; ch_grant stays 0.
- Reset mid-line: reset_n=0 in SHIFT cycle 4 -> the next cycle shows all outputs at reset values and line_count=0. After release, ch0 is granted first.
- line_count wrap with CNT_W=2: 5 lines -> count sequence 1,2,3,0,1.
